// File: rtl/wb_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   DATA_W / ADDR_W / NUM_REGS : writeback datapath geometry
//   CNT_W_DEFAULT              : default width of the contention counter
//   src_e                      : writeback source, also the round-robin pointer
package wb_pkg;

  localparam int DATA_W        = 64;
  localparam int ADDR_W        = 5;
  localparam int NUM_REGS      = 1 << ADDR_W;
  localparam int CNT_W_DEFAULT = 16;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] wb_data_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  // The source that gets priority after the given one wins a contention.
  function automatic src_e other_src(input src_e s);
    return (s == SRC_ALU) ? SRC_MEM : SRC_ALU;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two result sources, the issue stage, and the
// register-file write port.
//   alu_*/mem_*     : valid/ready writeback requests (rd + data)
//   issue_en/rd     : issued instruction that will later write issue_rd
//   rf_*            : registered drive of the register-file write port
//   pend_mask       : outstanding-write scoreboard, one bit per register
//   conflict_cnt    : saturating count of two-way contention cycles
// master = requesters/issue stage/observer, slave = the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int CNT_W = wb_pkg::CNT_W_DEFAULT
) ();
  import wb_pkg::*;

  logic                alu_valid;
  reg_idx_t            alu_rd;
  wb_data_t            alu_data;
  logic                alu_ready;

  logic                mem_valid;
  reg_idx_t            mem_rd;
  wb_data_t            mem_data;
  logic                mem_ready;

  logic                issue_en;
  reg_idx_t            issue_rd;

  reg_idx_t            rf_rd;
  wb_data_t            rf_wdata;
  logic                rf_regwrite;

  logic [NUM_REGS-1:0] pend_mask;
  logic [CNT_W-1:0]    conflict_cnt;

  modport master (
    output alu_valid, alu_rd, alu_data,
    input  alu_ready,
    output mem_valid, mem_rd, mem_data,
    input  mem_ready,
    output issue_en, issue_rd,
    input  rf_rd, rf_wdata, rf_regwrite,
    input  pend_mask, conflict_cnt
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    output alu_ready,
    input  mem_valid, mem_rd, mem_data,
    output mem_ready,
    input  issue_en, issue_rd,
    output rf_rd, rf_wdata, rf_regwrite,
    output pend_mask, conflict_cnt
  );

endinterface

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard for issue-stage RAW hazard detection.
//   clk, rst_n   : clock, async active-low reset
//   set_en_i/idx : issued producer of register set_idx_i (x0 ignored)
//   clr_en_i/idx : write-stage commit to register clr_idx_i
//   pend_mask_o  : bit i = write to register i still outstanding
module wb_scoreboard
  import wb_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_en_i,
  input  reg_idx_t            set_idx_i,
  input  logic                clr_en_i,
  input  reg_idx_t            clr_idx_i,
  output logic [NUM_REGS-1:0] pend_mask_o
);

  logic [NUM_REGS-1:0] pend_d;
  logic [NUM_REGS-1:0] pend_q;

  always_comb begin
    pend_d = pend_q;
    if (clr_en_i) begin
      pend_d[clr_idx_i] = 1'b0;
    end
    // Set applied after clear: a freshly issued producer of the same
    // register outranks the older write that is retiring this cycle.
    if (set_en_i && (set_idx_i != '0)) begin
      pend_d[set_idx_i] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  // NOTE: this is 32 individual flops, not a RAM macro, so it takes the
  // async reset; a true memory array would be left unreset and gated by valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend_mask_o = pend_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: two writeback sources (ALU, load) share
// the single 64-bit write port under round-robin arbitration.
//   clk    : system clock, rising edge
//   reset  : asynchronous active-low reset (0 = reset), deassert synchronised here
//   bus    : regfile_wb_arbiter_if.slave - requests, issue, rf drive, status
// Grant in cycle N drives rf_regwrite/rf_rd/rf_wdata in cycle N+1.
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  bus
);

  // ---------------------------------------------------------------------
  // Reset: assert asynchronously, release on a clock edge.
  // ---------------------------------------------------------------------
  logic [1:0] rst_sync_q;
  logic       rst_n;

  // NOTE: every clocked process uses non-blocking assignments so all flops
  // sample the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  // ---------------------------------------------------------------------
  // Round-robin arbiter (combinational ready, registered pointer)
  // ---------------------------------------------------------------------
  src_e     ptr_q;
  src_e     ptr_d;
  logic     both_valid;
  logic     grant_alu;
  logic     grant_mem;
  logic     wr_en_d;
  reg_idx_t rf_rd_d;
  reg_idx_t rf_rd_q;
  wb_data_t rf_wdata_d;
  wb_data_t rf_wdata_q;
  logic     rf_regwrite_q;

  assign both_valid = bus.alu_valid && bus.mem_valid;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    grant_alu  = 1'b0;
    grant_mem  = 1'b0;
    ptr_d      = ptr_q;
    wr_en_d    = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;

    if (both_valid) begin
      grant_alu = (ptr_q == SRC_ALU);
      grant_mem = (ptr_q == SRC_MEM);
      ptr_d     = other_src(ptr_q);
    end else begin
      grant_alu = bus.alu_valid;
      grant_mem = bus.mem_valid;
    end

    // A grant to x0 still completes the handshake but never reaches the
    // register file, so rf_rd/rf_wdata keep their previous values.
    if (grant_alu && (bus.alu_rd != '0)) begin
      wr_en_d    = 1'b1;
      rf_rd_d    = bus.alu_rd;
      rf_wdata_d = bus.alu_data;
    end else if (grant_mem && (bus.mem_rd != '0)) begin
      wr_en_d    = 1'b1;
      rf_rd_d    = bus.mem_rd;
      rf_wdata_d = bus.mem_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= SRC_ALU;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign bus.alu_ready = grant_alu;
  assign bus.mem_ready = grant_mem;

  // ---------------------------------------------------------------------
  // Write stage: one registered write per cycle
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_regwrite_q <= 1'b0;
      rf_rd_q       <= '0;
      rf_wdata_q    <= '0;
    end else begin
      rf_regwrite_q <= wr_en_d;
      rf_rd_q       <= rf_rd_d;
      rf_wdata_q    <= rf_wdata_d;
    end
  end

  assign bus.rf_regwrite = rf_regwrite_q;
  assign bus.rf_rd       = rf_rd_q;
  assign bus.rf_wdata    = rf_wdata_q;

  // ---------------------------------------------------------------------
  // Saturating contention counter
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (both_valid && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.conflict_cnt = cnt_q;

  // ---------------------------------------------------------------------
  // Pending-write scoreboard; clears on the commit cycle itself
  // ---------------------------------------------------------------------
  logic [NUM_REGS-1:0] pend_mask;

  wb_scoreboard u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .set_en_i    (bus.issue_en),
    .set_idx_i   (bus.issue_rd),
    .clr_en_i    (rf_regwrite_q),
    .clr_idx_i   (rf_rd_q),
    .pend_mask_o (pend_mask)
  );

  assign bus.pend_mask = pend_mask;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter. Expected register-file writes
// are queued as stimulus is issued; a monitor pops and compares on every
// rf_regwrite. Ready, scoreboard and counter values are checked inline.
module tb_regfile_wb_arbiter;
  import wb_pkg::*;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset;

  regfile_wb_arbiter_if #(.CNT_W(CNT_W)) bus ();

  regfile_wb_arbiter #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    reg_idx_t rd;
    wb_data_t data;
  } wr_t;

  wr_t  exp_q[$];
  int   n_vec  = 0;
  int   n_err  = 0;
  logic mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every committed write must match the oldest expected one.
  always @(negedge clk) begin
    wr_t e;
    if (mon_en && (bus.rf_regwrite !== 1'b0)) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got rd=%0d data=0x%0h, expected no write",
                 bus.rf_rd, bus.rf_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_regwrite", 64'(bus.rf_regwrite), 64'(1'b1));
        check("wr_rd", 64'(bus.rf_rd), 64'(e.rd));
        check("wr_data", bus.rf_wdata, e.data);
      end
    end
  end

  task automatic push(input reg_idx_t rd, input wb_data_t data);
    wr_t e;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic av, input reg_idx_t ard, input wb_data_t ad,
                       input logic mv, input reg_idx_t mrd, input wb_data_t md);
    bus.alu_valid = av;
    bus.alu_rd    = ard;
    bus.alu_data  = ad;
    bus.mem_valid = mv;
    bus.mem_rd    = mrd;
    bus.mem_data  = md;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // Inputs already applied; check readies mid-cycle, then advance past the edge.
  task automatic cyc(input string name, input logic exp_ar, input logic exp_mr);
    @(negedge clk);
    check({name, "_alu_ready"}, 64'(bus.alu_ready), 64'(exp_ar));
    check({name, "_mem_ready"}, 64'(bus.mem_ready), 64'(exp_mr));
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b0;
    bus.issue_en = 1'b0;
    bus.issue_rd = '0;
    idle();
    repeat (2) tick();
    release_reset();
    mon_en = 1'b1;

    // Reset state
    check("rst_regwrite", 64'(bus.rf_regwrite), 64'd0);
    check("rst_rf_rd", 64'(bus.rf_rd), 64'd0);
    check("rst_rf_wdata", bus.rf_wdata, 64'd0);
    check("rst_pend_mask", 64'(bus.pend_mask), 64'd0);
    check("rst_conflict", 64'(bus.conflict_cnt), 64'd0);

    // Single ALU write
    drive(1'b1, 5'd5, 64'hDEAD, 1'b0, '0, '0);
    push(5'd5, 64'hDEAD);
    cyc("t2", 1'b1, 1'b0);
    idle();
    tick();

    // Reset while a registered write is on the port
    drive(1'b1, 5'd3, 64'h33, 1'b1, 5'd4, 64'h44);
    bus.issue_en = 1'b1;
    bus.issue_rd = 5'd9;
    cyc("t1", 1'b1, 1'b0);
    bus.issue_en = 1'b0;
    check("t1_pre_regwrite", 64'(bus.rf_regwrite), 64'd1);
    check("t1_pre_rf_rd", 64'(bus.rf_rd), 64'd3);
    check("t1_pre_pend", 64'(bus.pend_mask), 64'h200);
    check("t1_pre_conflict", 64'(bus.conflict_cnt), 64'd1);
    #1;
    reset = 1'b0;
    idle();
    #1;
    check("t1_regwrite", 64'(bus.rf_regwrite), 64'd0);
    check("t1_rf_rd", 64'(bus.rf_rd), 64'd0);
    check("t1_rf_wdata", bus.rf_wdata, 64'd0);
    check("t1_pend", 64'(bus.pend_mask), 64'd0);
    check("t1_conflict", 64'(bus.conflict_cnt), 64'd0);
    release_reset();

    // Contention: pointer starts at ALU after reset
    drive(1'b1, 5'd1, 64'h11, 1'b1, 5'd2, 64'h22); push(5'd1, 64'h11); cyc("t3c1", 1'b1, 1'b0);
    drive(1'b1, 5'd1, 64'h12, 1'b1, 5'd2, 64'h22); push(5'd2, 64'h22); cyc("t3c2", 1'b0, 1'b1);
    drive(1'b1, 5'd1, 64'h12, 1'b1, 5'd2, 64'h23); push(5'd1, 64'h12); cyc("t3c3", 1'b1, 1'b0);
    drive(1'b1, 5'd1, 64'h13, 1'b1, 5'd2, 64'h23); push(5'd2, 64'h23); cyc("t3c4", 1'b0, 1'b1);
    check("t3_conflict4", 64'(bus.conflict_cnt), 64'd4);
    drive(1'b1, 5'd1, 64'h13, 1'b0, '0, '0);       push(5'd1, 64'h13); cyc("t3c5", 1'b1, 1'b0);
    // Single grant above left the pointer at ALU
    drive(1'b1, 5'd1, 64'h14, 1'b1, 5'd2, 64'h24); push(5'd1, 64'h14); cyc("t3c6", 1'b1, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 5'd2, 64'h24);       push(5'd2, 64'h24); cyc("t3c7", 1'b0, 1'b1);
    idle();
    check("t3_conflict5", 64'(bus.conflict_cnt), 64'd5);

    // Scoreboard set and clear
    bus.issue_en = 1'b1;
    bus.issue_rd = 5'd7;
    tick();
    bus.issue_en = 1'b0;
    check("t4_set", 64'(bus.pend_mask), 64'h80);
    drive(1'b0, '0, '0, 1'b1, 5'd7, 64'h77);
    push(5'd7, 64'h77);
    cyc("t4_wr", 1'b0, 1'b1);
    idle();
    check("t4_commit_cycle", 64'(bus.pend_mask), 64'h80);
    tick();
    check("t4_cleared", 64'(bus.pend_mask), 64'd0);

    // Issue and commit of the same register in one cycle: issue wins
    bus.issue_en = 1'b1;
    tick();
    bus.issue_en = 1'b0;
    drive(1'b0, '0, '0, 1'b1, 5'd7, 64'h78);
    push(5'd7, 64'h78);
    cyc("t4_wr2", 1'b0, 1'b1);
    idle();
    bus.issue_en = 1'b1;
    tick();
    bus.issue_en = 1'b0;
    check("t4_set_wins", 64'(bus.pend_mask), 64'h80);
    check("hold_regwrite", 64'(bus.rf_regwrite), 64'd0);
    check("hold_rf_rd", 64'(bus.rf_rd), 64'd7);
    check("hold_rf_wdata", bus.rf_wdata, 64'h78);

    // Write and issue to x0
    drive(1'b1, 5'd0, 64'hFF, 1'b0, '0, '0);
    bus.issue_en = 1'b1;
    bus.issue_rd = 5'd0;
    cyc("t5", 1'b1, 1'b0);
    idle();
    bus.issue_en = 1'b0;
    check("t5_regwrite", 64'(bus.rf_regwrite), 64'd0);
    check("t5_pend", 64'(bus.pend_mask), 64'h80);

    // Continuous contention: counter 5 -> saturates at 15; pointer is at MEM
    drive(1'b1, 5'd10, 64'hA0, 1'b1, 5'd11, 64'hB0);
    for (int i = 0; i < 14; i++) begin
      if ((i % 2) == 0) begin
        push(5'd11, 64'hB0);
        cyc("t6", 1'b0, 1'b1);
      end else begin
        push(5'd10, 64'hA0);
        cyc("t6", 1'b1, 1'b0);
      end
      if (i == 8)  check("t6_cnt14", 64'(bus.conflict_cnt), 64'd14);
      if (i == 9)  check("t6_cnt15", 64'(bus.conflict_cnt), 64'd15);
      if (i == 13) check("t6_no_wrap", 64'(bus.conflict_cnt), 64'd15);
    end
    idle();
    repeat (3) tick();
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
